// File: rtl/wb_stage_grf_if.sv
// MEM/WB to write-back bundle: W-stage inputs, D-stage read ports, retire trace.
// The stage never stalls, so there is no ready; every presented write is consumed.
interface wb_stage_grf_if;
    logic [4:0]  W_WR;
    logic [31:0] W_DR;
    logic [31:0] W_AO;
    logic [31:0] W_pc;
    logic [31:0] W_pc_add_8;
    logic        RegWrite_W;
    logic [1:0]  MemtoReg_W;
    logic [2:0]  DMOp_W;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic [31:0] W_wdata;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [31:0] retire_count;

    modport master (
        output W_WR, W_DR, W_AO, W_pc, W_pc_add_8, RegWrite_W, MemtoReg_W, DMOp_W,
               D_rs_addr, D_rt_addr,
        input  D_rs_data, D_rt_data, W_wdata, trace_valid, trace_pc, trace_addr,
               trace_data, retire_count
    );

    modport slave (
        input  W_WR, W_DR, W_AO, W_pc, W_pc_add_8, RegWrite_W, MemtoReg_W, DMOp_W,
               D_rs_addr, D_rt_addr,
        output D_rs_data, D_rt_data, W_wdata, trace_valid, trace_pc, trace_addr,
               trace_data, retire_count
    );
endinterface

// File: rtl/wb_stage_grf.sv
// Write-back select/load extension, 32x32 GRF with write-through read bypass, retire trace.
// Reads see the same-cycle write (0 latency); trace/counter lag one cycle; never stalls.
module wb_stage_grf #(
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h3000
) (
    input  logic         clk,
    input  logic         reset,
    wb_stage_grf_if.slave wb
);
    localparam int AW = $clog2(NREG);

    logic [31:0] grf_q [NREG];
    logic [31:0] grf_d [NREG];
    logic        trace_valid_q, trace_valid_d;
    logic [31:0] trace_pc_q,    trace_pc_d;
    logic [4:0]  trace_addr_q,  trace_addr_d;
    logic [31:0] trace_data_q,  trace_data_d;
    logic [31:0] retire_count_q, retire_count_d;

    logic [31:0] load_ext;
    logic [31:0] wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        we;

    assign byte_sel = wb.W_DR[{wb.W_AO[1:0], 3'b000} +: 8];
    assign half_sel = wb.W_AO[1] ? wb.W_DR[31:16] : wb.W_DR[15:0];

    always_comb begin
        load_ext = wb.W_DR;
        case (wb.DMOp_W)
            3'd1:    load_ext = {24'h0, byte_sel};
            3'd2:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd3:    load_ext = {16'h0, half_sel};
            3'd4:    load_ext = {{16{half_sel[15]}}, half_sel};
            default: load_ext = wb.W_DR;
        endcase
    end

    always_comb begin
        wdata = 32'h0;
        case (wb.MemtoReg_W)
            2'd0:    wdata = wb.W_AO;
            2'd1:    wdata = load_ext;
            2'd2:    wdata = wb.W_pc_add_8;
            default: wdata = 32'h0;
        endcase
    end

    // Gating with reset also suppresses the bypass for a write presented in the reset cycle.
    assign we = wb.RegWrite_W && (wb.W_WR != 5'd0) && !reset;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            grf_d[i] = grf_q[i];
            if (reset)
                grf_d[i] = 32'h0;
            else if (we && (wb.W_WR == AW'(i)))
                grf_d[i] = wdata;
        end

        trace_valid_d  = we;
        trace_pc_d     = trace_pc_q;
        trace_addr_d   = trace_addr_q;
        trace_data_d   = trace_data_q;
        retire_count_d = retire_count_q;
        if (reset) begin
            trace_valid_d  = 1'b0;
            trace_pc_d     = RESET_PC;
            trace_addr_d   = 5'd0;
            trace_data_d   = 32'h0;
            retire_count_d = 32'h0;
        end else if (we) begin
            trace_pc_d     = wb.W_pc;
            trace_addr_d   = wb.W_WR;
            trace_data_d   = wdata;
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++)
            grf_q[i] <= grf_d[i];
        trace_valid_q  <= trace_valid_d;
        trace_pc_q     <= trace_pc_d;
        trace_addr_q   <= trace_addr_d;
        trace_data_q   <= trace_data_d;
        retire_count_q <= retire_count_d;
    end

    always_comb begin
        wb.D_rs_data = grf_q[wb.D_rs_addr];
        if (wb.D_rs_addr == 5'd0)
            wb.D_rs_data = 32'h0;
        else if (we && (wb.D_rs_addr == wb.W_WR))
            wb.D_rs_data = wdata;
    end

    always_comb begin
        wb.D_rt_data = grf_q[wb.D_rt_addr];
        if (wb.D_rt_addr == 5'd0)
            wb.D_rt_data = 32'h0;
        else if (we && (wb.D_rt_addr == wb.W_WR))
            wb.D_rt_data = wdata;
    end

    assign wb.W_wdata      = wdata;
    assign wb.trace_valid  = trace_valid_q;
    assign wb.trace_pc     = trace_pc_q;
    assign wb.trace_addr   = trace_addr_q;
    assign wb.trace_data   = trace_data_q;
    assign wb.retire_count = retire_count_q;
endmodule

// File: tb/tb_wb_stage_grf.sv
// Directed bench for wb_stage_grf: reset state, bypass, load extension, $0, jal, wrap, mid-stream reset.
module tb_wb_stage_grf;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    wb_stage_grf_if wb ();

    wb_stage_grf #(.NREG(32), .RESET_PC(32'h3000)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents an instruction on the negedge so it is sampled by the following posedge.
    task automatic present(input logic we, input logic [4:0] wr, input logic [1:0] m2r,
                           input logic [2:0] dmop, input logic [31:0] ao, input logic [31:0] dr,
                           input logic [31:0] pc, input logic [31:0] pc8);
        @(negedge clk);
        wb.RegWrite_W = we;
        wb.W_WR       = wr;
        wb.MemtoReg_W = m2r;
        wb.DMOp_W     = dmop;
        wb.W_AO       = ao;
        wb.W_DR       = dr;
        wb.W_pc       = pc;
        wb.W_pc_add_8 = pc8;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        wb.RegWrite_W = 1'b0;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  dmop;
        logic [31:0] ao;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads [5];

    initial begin
        loads[0] = '{3'd2, 32'h0000_0103, 32'hFFFF_FF80};
        loads[1] = '{3'd1, 32'h0000_0102, 32'h0000_00FF};
        loads[2] = '{3'd4, 32'h0000_0102, 32'hFFFF_80FF};
        loads[3] = '{3'd3, 32'h0000_0100, 32'h0000_7F01};
        loads[4] = '{3'd0, 32'h0000_0100, 32'h80FF_7F01};

        reset = 1'b1;
        wb.RegWrite_W = 1'b0;
        wb.W_WR = 5'd0;
        wb.W_DR = 32'h0;
        wb.W_AO = 32'h0;
        wb.W_pc = 32'h0;
        wb.W_pc_add_8 = 32'h0;
        wb.MemtoReg_W = 2'd0;
        wb.DMOp_W = 3'd0;
        wb.D_rs_addr = 5'd0;
        wb.D_rt_addr = 5'd0;
        after_edge();
        after_edge();
        @(negedge clk);
        reset = 1'b0;

        // Reset state of every register on both ports
        for (int i = 0; i < 32; i++) begin
            wb.D_rs_addr = 5'(i);
            wb.D_rt_addr = 5'(31 - i);
            #1;
            check_val($sformatf("rst_rs%0d", i), wb.D_rs_data, 32'h0);
            check_val($sformatf("rst_rt%0d", 31 - i), wb.D_rt_data, 32'h0);
        end
        check_val("rst_count", wb.retire_count, 32'h0);
        check_val("rst_tvalid", {31'h0, wb.trace_valid}, 32'h0);
        check_val("rst_tpc", wb.trace_pc, 32'h3000);

        // ALU write with same-cycle bypass on both ports
        wb.D_rs_addr = 5'd5;
        wb.D_rt_addr = 5'd5;
        present(1'b1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0000_3000, 32'h0000_3008);
        check_val("byp_rs", wb.D_rs_data, 32'h1234_5678);
        check_val("byp_rt", wb.D_rt_data, 32'h1234_5678);
        after_edge();
        check_val("alu_tvalid", {31'h0, wb.trace_valid}, 32'h1);
        check_val("alu_taddr", {27'h0, wb.trace_addr}, 32'd5);
        check_val("alu_tdata", wb.trace_data, 32'h1234_5678);
        check_val("alu_count", wb.retire_count, 32'd1);

        // Load extension sweep into $10..$14
        for (int i = 0; i < 5; i++) begin
            present(1'b1, 5'(10 + i), 2'd1, loads[i].dmop, loads[i].ao, 32'h80FF_7F01,
                    32'h0000_3004, 32'h0000_300C);
            check_val($sformatf("load%0d_wdata", i), wb.W_wdata, loads[i].exp);
        end
        idle();
        check_val("load_count", wb.retire_count, 32'd6);
        check_val("load_tvalid", {31'h0, wb.trace_valid}, 32'h1);
        after_edge();
        check_val("idle_tvalid", {31'h0, wb.trace_valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            wb.D_rs_addr = 5'(10 + i);
            #1;
            check_val($sformatf("load%0d_rd", i), wb.D_rs_data, loads[i].exp);
        end
        wb.D_rt_addr = 5'd5;
        #1;
        check_val("r5_hold", wb.D_rt_data, 32'h1234_5678);

        // DMOp 5 passes the raw word; MemtoReg 3 selects zero
        present(1'b0, 5'd1, 2'd1, 3'd5, 32'h0000_0101, 32'hA5A5_5A5A, 32'h0, 32'h0);
        check_val("dmop5", wb.W_wdata, 32'hA5A5_5A5A);
        present(1'b0, 5'd1, 2'd3, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
        check_val("m2r3", wb.W_wdata, 32'h0);

        // Write to $0 is dropped
        wb.D_rs_addr = 5'd0;
        present(1'b1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0000_3020, 32'h0);
        check_val("r0_byp", wb.D_rs_data, 32'h0);
        after_edge();
        check_val("r0_tvalid", {31'h0, wb.trace_valid}, 32'h0);
        check_val("r0_count", wb.retire_count, 32'd6);
        check_val("r0_taddr_hold", {27'h0, wb.trace_addr}, 32'd14);
        check_val("r0_tdata_hold", wb.trace_data, 32'h80FF_7F01);
        check_val("r0_rd", wb.D_rs_data, 32'h0);

        // jal link write
        wb.D_rt_addr = 5'd31;
        present(1'b1, 5'd31, 2'd2, 3'd0, 32'h0000_4000, 32'h0, 32'h0000_3008, 32'h0000_3010);
        check_val("jal_byp", wb.D_rt_data, 32'h0000_3010);
        after_edge();
        check_val("jal_tpc", wb.trace_pc, 32'h0000_3008);
        check_val("jal_taddr", {27'h0, wb.trace_addr}, 32'd31);
        check_val("jal_count", wb.retire_count, 32'd7);
        idle();
        check_val("jal_rd", wb.D_rt_data, 32'h0000_3010);

        // Counter wrap
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        #1;
        check_val("wrap_pre", wb.retire_count, 32'hFFFF_FFFF);
        present(1'b1, 5'd3, 2'd0, 3'd0, 32'h0000_0033, 32'h0, 32'h0000_3030, 32'h0);
        after_edge();
        check_val("wrap_count", wb.retire_count, 32'h0);
        check_val("wrap_tvalid", {31'h0, wb.trace_valid}, 32'h1);

        // Reset arriving with a write to $7 in W
        wb.D_rs_addr = 5'd7;
        wb.D_rt_addr = 5'd5;
        @(negedge clk);
        reset = 1'b1;
        present(1'b1, 5'd7, 2'd0, 3'd0, 32'h0000_0055, 32'h0, 32'h0000_3040, 32'h0);
        check_val("rst_nobyp", wb.D_rs_data, 32'h0);
        after_edge();
        check_val("mrst_tvalid", {31'h0, wb.trace_valid}, 32'h0);
        check_val("mrst_tpc", wb.trace_pc, 32'h3000);
        check_val("mrst_count", wb.retire_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wb.RegWrite_W = 1'b0;
        #1;
        check_val("mrst_r7", wb.D_rs_data, 32'h0);
        check_val("mrst_r5", wb.D_rt_data, 32'h0);

        // First write after reset is recorded normally
        present(1'b1, 5'd7, 2'd0, 3'd0, 32'h0000_0077, 32'h0, 32'h0000_3050, 32'h0);
        after_edge();
        check_val("post_tvalid", {31'h0, wb.trace_valid}, 32'h1);
        check_val("post_tdata", wb.trace_data, 32'h0000_0077);
        check_val("post_count", wb.retire_count, 32'd1);
        idle();
        check_val("post_r7", wb.D_rs_data, 32'h0000_0077);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
